// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared parameters, state encoding and fixed-point constants for the CORDIC rotator
package cordic_pkg;

  // Default datapath width and micro-rotation count
  localparam int W_DEF     = 32;
  localparam int NITER_DEF = 24;

  // Width of the external iteration counter / ROM address
  localparam int CNT_W = 6;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  // CORDIC gain 1/An in Q1.30, used by callers to pre-scale x/y
  localparam logic [31:0] K_Q130    = 32'h26DD3B6A;
  // pi/2 in Q2.29
  localparam logic [31:0] PI_2_Q229 = 32'h3243F6A8;

  // Counter value seen during the final micro-rotation
  function automatic logic [CNT_W-1:0] last_count(input int niter);
    return CNT_W'(niter - 1);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// rtl/cordic_stage.sv - one combinational CORDIC micro-rotation
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic [W-1:0]     z,
  input  logic [CNT_W-1:0] i,
  input  logic [W-1:0]     atan,
  input  logic             d_neg,
  output logic [W-1:0]     x_next,
  output logic [W-1:0]     y_next,
  output logic [W-1:0]     z_next
);

  logic [W-1:0] x_sh;
  logic [W-1:0] y_sh;

  // Arithmetic shifts by the iteration index; shifts past W leave only sign bits
  always_comb begin
    x_sh = $signed(x) >>> i;
    y_sh = $signed(y) >>> i;
  end

  // Rotate toward z = 0; d = -1 when z is negative, zero counts as non-negative
  always_comb begin
    x_next = x;
    y_next = y;
    z_next = z;
    if (d_neg) begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + atan;
    end else begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - atan;
    end
  end

endmodule

// File: rtl/cordic_rot_core.sv
// rtl/cordic_rot_core.sv - iterative rotation-mode CORDIC controller and working registers
module cordic_rot_core
  import cordic_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int NITER = NITER_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [W-1:0]     x_in,
  input  logic [W-1:0]     y_in,
  input  logic [W-1:0]     z_in,
  input  logic [CNT_W-1:0] count,
  input  logic [W-1:0]     atan_val,
  output logic             start_iter,
  output logic [W-1:0]     x_out,
  output logic [W-1:0]     y_out,
  output logic [W-1:0]     z_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_CNT = last_count(NITER);

  state_t state;
  state_t state_nxt;

  logic         last_iter;
  logic [W-1:0] x_nxt;
  logic [W-1:0] y_nxt;
  logic [W-1:0] z_nxt;

  // Termination trusts the counter being in lock-step with ROT entry
  assign last_iter = (count == LAST_CNT);

  cordic_stage #(
    .W(W)
  ) u_stage (
    .x      (x_out),
    .y      (y_out),
    .z      (z_out),
    .i      (count),
    .atan   (atan_val),
    .d_neg  (z_out[W-1]),
    .x_next (x_nxt),
    .y_next (y_nxt),
    .z_next (z_nxt)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and Moore output decode from the state register only
  always_comb begin
    state_nxt  = state;
    start_iter = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_nxt = ROT;
      end
      ROT: begin
        start_iter = 1'b0;
        busy       = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Working registers: load on accepted start, rotate in ROT, hold otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else if (state == IDLE && en) begin
      x_out <= x_in;
      y_out <= y_in;
      z_out <= z_in;
    end else if (state == ROT) begin
      x_out <= x_nxt;
      y_out <= y_nxt;
      z_out <= z_nxt;
    end
  end

endmodule

// File: tb/tb_cordic_rot_core.sv
// tb/tb_cordic_rot_core.sv - scoreboard bench for cordic_rot_core with counter and atan ROM models
module tb_cordic_rot_core;
  import cordic_pkg::*;

  localparam int W     = 32;
  localparam int NITER = 24;
  localparam real KGAIN = 0.6072529350088812;
  localparam real Q29   = 536870912.0;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] x_in, y_in, z_in;
  logic [5:0]  count = 6'd0;
  logic [31:0] atan_val;
  logic        start_iter;
  logic [31:0] x_out, y_out, z_out;
  logic        busy, done;

  always #5 clock = ~clock;

  cordic_rot_core #(.W(W), .NITER(NITER)) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .x_in       (x_in),
    .y_in       (y_in),
    .z_in       (z_in),
    .count      (count),
    .atan_val   (atan_val),
    .start_iter (start_iter),
    .x_out      (x_out),
    .y_out      (y_out),
    .z_out      (z_out),
    .busy       (busy),
    .done       (done)
  );

  // External iteration counter and arctangent ROM
  int atan_tab[64];
  assign atan_val = atan_tab[count];
  always @(posedge clock) count <= start_iter ? 6'd0 : count + 6'd1;

  typedef struct {
    int x, y, z;
    int xi, yi, zi;
    int done_edge;
    bit analytic;
  } exp_t;

  exp_t sb[$];
  int  checks = 0, errors = 0;
  int  cyc = 0, free_at = 0, act_start = 0;
  bit  act_valid = 0, started = 0, analytic_next = 0;
  int  hold_x = 0, hold_y = 0, hold_z = 0;

  function automatic int s32(input logic [31:0] v);
    return $signed(v);
  endfunction

  function void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 25) $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endfunction

  function void chk_tol(input string name, input longint act, input longint exp, input longint tol);
    longint diff;
    checks++;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      if (errors <= 25) $display("FAIL %s at edge %0d: got %0d expected %0d +/- %0d", name, cyc, act, exp, tol);
    end
  endfunction

  // Reference: NITER micro-rotations straight from the rotation rules
  function automatic exp_t model(input int xi, input int yi, input int zi);
    exp_t e;
    int x, y, z, xs, ys;
    x = xi; y = yi; z = zi;
    for (int i = 0; i < NITER; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (z < 0) begin
        x = x + ys; y = y - xs; z = z + atan_tab[i];
      end else begin
        x = x - ys; y = y + xs; z = z - atan_tab[i];
      end
    end
    e.x = x; e.y = y; e.z = z;
    e.xi = xi; e.yi = yi; e.zi = zi;
    e.done_edge = 0;
    e.analytic = 0;
    return e;
  endfunction

  // Predictor: decides acceptance from its own occupancy model and queues the result
  always @(posedge clock) begin
    exp_t e;
    cyc++;
    if (reset) begin
      sb.delete();
      act_valid = 0;
      free_at = 0;
      hold_x = 0; hold_y = 0; hold_z = 0;
    end else if (en && cyc >= free_at) begin
      e = model(s32(x_in), s32(y_in), s32(z_in));
      e.done_edge = cyc + NITER;
      e.analytic = analytic_next;
      sb.push_back(e);
      act_valid = 1;
      act_start = cyc;
      free_at = cyc + NITER + 2;
      hold_x = e.x; hold_y = e.y; hold_z = e.z;
    end
  end

  // Monitor: status every cycle, results whenever done is presented
  always @(negedge clock) begin
    bit eb, er, ed;
    exp_t e;
    real th, ex, ey;
    if (started) begin
      eb = act_valid && cyc >= act_start && cyc <= act_start + NITER;
      er = act_valid && cyc >= act_start && cyc < act_start + NITER;
      ed = eb && !er;
      chk("busy", busy, eb);
      chk("start_iter", start_iter, !er);
      chk("done", done, ed);
      if (er) chk("count", count, cyc - act_start);
      if (!eb || ed) begin
        chk("x_hold", s32(x_out), hold_x);
        chk("y_hold", s32(y_out), hold_y);
        chk("z_hold", s32(z_out), hold_z);
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_edge", cyc, e.done_edge);
          chk("x_result", s32(x_out), e.x);
          chk("y_result", s32(y_out), e.y);
          chk("z_result", s32(z_out), e.z);
          if (e.analytic) begin
            th = $itor(e.zi - e.z) / Q29;
            ex = ($itor(e.xi) * $cos(th) - $itor(e.yi) * $sin(th)) / KGAIN;
            ey = ($itor(e.yi) * $cos(th) + $itor(e.xi) * $sin(th)) / KGAIN;
            chk_tol("x_analytic", s32(x_out), longint'(ex), 64);
            chk_tol("y_analytic", s32(y_out), longint'(ey), 64);
            chk_tol("z_residual", s32(z_out), 0, 80);
          end
        end
      end else if (sb.size() > 0 && sb[0].done_edge < cyc) begin
        e = sb.pop_front();
        chk("done_missing", 0, 1);
      end
    end
  end

  task automatic wait_free();
    while (cyc + 1 < free_at) @(negedge clock);
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z, input bit analytic);
    wait_free();
    x_in = x; y_in = y; z_in = z;
    analytic_next = analytic;
    en = 1'b1;
    @(negedge clock);
    en = 1'b0;
    analytic_next = 0;
  endtask

  initial begin
    int e0, t;
    for (int i = 0; i < 64; i++)
      atan_tab[i] = $rtoi($atan(2.0 ** (-i)) * Q29 + 0.5);
    reset = 1'b1; en = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_start_iter", start_iter, 1);
    chk("reset_x", x_out, 0);
    started = 1;
    reset = 1'b0;
    @(negedge clock);

    // Directed angles: 0, pi/2, -pi/4
    run_op(K_Q130, 32'd0, 32'd0, 1);
    run_op(K_Q130, 32'd0, PI_2_Q229, 1);
    run_op(K_Q130, 32'd0, 32'hE6DE04AC, 1);

    // en during ROT cycles 3 and 10 and during done must be ignored
    run_op(K_Q130, 32'd0, 32'h10000000, 1);
    e0 = cyc;
    while (cyc < e0 + 3) @(negedge clock);
    x_in = $urandom; y_in = $urandom; z_in = $urandom; en = 1'b1;
    @(negedge clock); en = 1'b0;
    while (cyc < e0 + 10) @(negedge clock);
    x_in = $urandom; en = 1'b1;
    @(negedge clock); en = 1'b0;
    while (cyc < e0 + NITER) @(negedge clock);
    chk("done_cycle_seen", done, 1);
    x_in = $urandom; en = 1'b1;
    @(negedge clock); en = 1'b0;
    repeat (4) @(negedge clock);

    // Reset in ROT cycle 7 aborts, then a full run follows
    run_op($urandom, $urandom, $urandom, 0);
    e0 = cyc;
    while (cyc < e0 + 7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_x", x_out, 0);
    chk("abort_y", y_out, 0);
    chk("abort_z", z_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_start_iter", start_iter, 1);
    run_op(K_Q130, 32'h10000000, 32'hF0000000, 1);

    // Back-to-back: en held high, inputs changing each cycle
    wait_free();
    en = 1'b1;
    for (int c = 0; c < 3 * (NITER + 2); c++) begin
      x_in = $urandom; y_in = $urandom; z_in = $urandom;
      @(negedge clock);
    end
    en = 1'b0;

    // Random operations with random gaps
    for (int n = 0; n < 20; n++) begin
      run_op($urandom, $urandom, $urandom, 0);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    t = 0;
    while ((sb.size() > 0 || cyc < free_at) && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
